fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the single-cycle-to-pipelined MIPS datapath: holds the word-addressed program counter, drives the 8-bit address into the instruction memory, and registers the returned 32-bit instruction into the IF/ID pipeline register for the decode stage. Supports stall (hold), redirect (branch/jump with flush), a terminal halt state, and a count of instructions delivered to decode.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall_i  input  1  decode/hazard stall: hold PC and IF/ID.
- redirect_i  input  1  taken branch or jump resolved downstream.
- redirect_pc_i  input  8  word address of redirect target.
- halt_i  input  1  stop fetching; sticky until reset.
- pc_o  output  8  current PC, wired to instruction memory address A.
- instr_i  input  32  instruction memory read data RD (combinational from pc_o).
- instr_d  output  32  IF/ID instruction.
- pc_plus1_d  output  8  IF/ID PC+1 of the captured instruction (branch base).
- valid_d  output  1  IF/ID contents are a real instruction.
- halted_o  output  1  high in HALT state.
- fetch_count_o  output  CNT_W  instructions delivered to decode since reset.

## Operation
- PC is word-addressed; sequential next PC = pc_o + 1, modulo 256 (8'hFF -> 8'h00, no flag).
- States: RUN, HALT. Reset -> RUN. RUN -> HALT on halt_i=1 (any cycle, including during stall or with redirect). HALT -> RUN only by rst.
- Per-edge priority in RUN: halt_i > redirect_i > stall_i > normal.
  - halt_i: PC holds, valid_d <= 0, instr_d/pc_plus1_d hold, enter HALT.
  - redirect_i: pc_o <= redirect_pc_i; valid_d <= 0 (flush the wrong-path instruction); instr_d/pc_plus1_d hold. Redirect overrides a simultaneous stall.
  - stall_i: pc_o, instr_d, pc_plus1_d, valid_d all hold.
  - normal: instr_d <= instr_i; pc_plus1_d <= pc_o + 1; valid_d <= 1; pc_o <= pc_o + 1.
- HALT: pc_o, instr_d, pc_plus1_d hold; valid_d = 0; inputs other than rst ignored.
- fetch_count_o increments by 1 on every edge that loads valid_d <= 1 (normal case only); wraps modulo 2^CNT_W; never increments on stall, redirect, halt.
- Reset (async, any time incl. mid-stall or HALT): pc_o = RESET_PC, instr_d = 32'h0, pc_plus1_d = 8'h0, valid_d = 0, halted_o = 0, fetch_count_o = 0, state RUN. Outputs take reset values immediately on rst assertion, not at next edge.

## Timing
- Instruction memory is combinational: instr_i valid within the cycle pc_o is presented.
- Latency: instruction at address X appears on instr_d with valid_d=1 exactly one edge after the edge on which pc_o became X, provided no stall/redirect/halt on that edge.
- First edge after rst deasserts captures instruction at RESET_PC.
- Redirect cost: one bubble (valid_d=0 for one cycle); target instruction valid on instr_d two edges after redirect_i sampled high.
- Stall of N cycles delays all outputs exactly N cycles; no instruction lost or duplicated.
- halted_o registered: rises on the edge halt_i is sampled.

## Test plan
- Sequential fetch, mem[0]=32'h20010003, mem[1]=32'h20020009: release reset -> edge 1 instr_d=32'h20010003, pc_plus1_d=1, valid_d=1; edge 2 instr_d=32'h20020009, pc_plus1_d=2; fetch_count_o=2.
- Stall 3 cycles while pc_o=5 -> pc_o stays 5, instr_d/valid_d unchanged 3 cycles, fetch_count unchanged; then resumes with mem[5].
- Redirect to 8'h08 with stall_i=1 simultaneously at pc_o=3 -> next cycle pc_o=8, valid_d=0; following edge instr_d=mem[8], pc_plus1_d=9, valid_d=1.
- Wrap: run from RESET_PC=8'hFE -> pc_o sequence FE, FF, 00; pc_plus1_d for mem[FF] = 8'h00.
- Halt with redirect_i=1 same edge -> halted_o=1, valid_d=0, pc_o unchanged; further redirect/stall ignored 10 cycles.
- Async rst asserted mid-cycle during HALT -> all outputs at reset values before next edge; normal fetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS datapath.
// Holds the word-addressed PC, presents it to the combinational instruction
// memory, and registers the returned word into the IF/ID register.
// Supports stall, redirect with flush, a sticky halt and a delivered count.
module fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [7:0]       redirect_pc_i,
  input  logic             halt_i,
  output logic [7:0]       pc_o,
  input  logic [31:0]      instr_i,
  output logic [31:0]      instr_d,
  output logic [7:0]       pc_plus1_d,
  output logic             valid_d,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_count_o
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state_reg;
  logic [7:0] pc_plus1_next;

  // Sequential PC; 8-bit add wraps FF -> 00 naturally.
  assign pc_plus1_next = pc_o + 8'd1;

  // Fetch FSM: priority halt > redirect > stall > normal fetch while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      pc_o          <= RESET_PC;
      instr_d       <= 32'h0;
      pc_plus1_d    <= 8'h0;
      valid_d       <= 1'b0;
      halted_o      <= 1'b0;
      fetch_count_o <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (halt_i) begin
            // Freeze PC and IF/ID contents; drop the valid bit for good.
            state_reg <= HALT;
            halted_o  <= 1'b1;
            valid_d   <= 1'b0;
          end else if (redirect_i) begin
            // Wrong-path word is discarded; target is fetched next cycle.
            pc_o    <= redirect_pc_i;
            valid_d <= 1'b0;
          end else if (!stall_i) begin
            instr_d       <= instr_i;
            pc_plus1_d    <= pc_plus1_next;
            valid_d       <= 1'b1;
            pc_o          <= pc_plus1_next;
            fetch_count_o <= fetch_count_o + CNT_ONE;
          end
          // Stall: everything holds.
        end
        HALT: begin
          // Only reset leaves HALT; all other inputs are ignored.
          valid_d  <= 1'b0;
          halted_o <= 1'b1;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

endmodule
